// File: rtl/fastica_pkg.sv
// Shared FastICA datapath constants, lane indexing helpers and the
// accumulate/update stage state encoding.
package fastica_pkg;

  localparam int unsigned DATA_W = 26;
  localparam int unsigned FRAC_W = 13;
  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 4;
  localparam int unsigned LANES  = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } acc_state_e;

  function automatic int unsigned lane_idx(input int unsigned row, input int unsigned col);
    return row * COLS + col;
  endfunction

endpackage

// File: rtl/one_unit_acc_lane.sv
// One lane of the one-unit update: sample accumulator, mean minus 3*w, fit().
// Build option ONE_UNIT_ACC_SAT_EN selects saturation instead of wrap in fit().
module one_unit_acc_lane #(
  parameter int unsigned DATA_W       = 26,
  parameter int unsigned LOG2_SAMPLES = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     clr_i,
  input  logic                     acc_en_i,
  input  logic                     fin_en_i,
  input  logic signed [DATA_W-1:0] prod_i,
  input  logic signed [DATA_W-1:0] w_i,
  output logic        [DATA_W-1:0] w_new_o
);

  localparam int unsigned ACC_W = DATA_W + LOG2_SAMPLES + 2;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  mean, w_ext, w3, diff;
  logic        [DATA_W-1:0] w_new_q, w_new_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)         acc_d = '0;
    else if (acc_en_i) acc_d = acc_q + ACC_W'(prod_i);
  end

  // Mean uses an arithmetic shift, so negative sums floor toward -inf.
  always_comb begin
    mean  = acc_q >>> LOG2_SAMPLES;
    w_ext = ACC_W'(w_i);
    w3    = (w_ext <<< 1) + w_ext;
    diff  = mean - w3;
  end

`ifdef ONE_UNIT_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  always_comb begin
    w_new_d = w_new_q;
    if (fin_en_i) begin
      if (diff > MAX_V)      w_new_d = MAX_V[DATA_W-1:0];
      else if (diff < MIN_V) w_new_d = MIN_V[DATA_W-1:0];
      else                   w_new_d = DATA_W'(diff);
    end
  end
`else
  always_comb begin
    w_new_d = w_new_q;
    if (fin_en_i) w_new_d = DATA_W'(diff);
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q   <= '0;
      w_new_q <= '0;
    end else begin
      acc_q   <= acc_d;
      w_new_q <= w_new_d;
    end
  end

  assign w_new_o = w_new_q;

endmodule

// File: rtl/one_unit_acc.sv
// Accumulates per-sample one-unit products and forms w_new = E{z*g(w^T z)} - 3*w.
// Build option ONE_UNIT_ACC_SAT_EN: saturate lane results instead of wrapping.
module one_unit_acc #(
  parameter int unsigned DATA_W       = fastica_pkg::DATA_W,
  parameter int unsigned FRAC_W       = fastica_pkg::FRAC_W,
  parameter int unsigned LANES        = fastica_pkg::LANES,
  parameter int unsigned LOG2_SAMPLES = 10
) (
  input  logic                    clk_acc,
  input  logic                    rst_acc_n,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [LANES*DATA_W-1:0] prod,
  input  logic [LANES*DATA_W-1:0] w_cur,
  output logic                    busy,
  output logic [LOG2_SAMPLES-1:0] sample_cnt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] w_new
);

  import fastica_pkg::*;

  if (FRAC_W >= DATA_W || LOG2_SAMPLES < 1) begin : g_param_check
    $error("one_unit_acc: need FRAC_W < DATA_W and LOG2_SAMPLES >= 1");
  end

  acc_state_e              state_q, state_d;
  logic [LOG2_SAMPLES-1:0] cnt_q, cnt_d;
  logic                    clr, acc_en, fin_en;

  // start overrides every state, and a sample arriving alongside it is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    acc_en  = 1'b0;
    fin_en  = 1'b0;
    if (start) begin
      state_d = ACCUM;
      cnt_d   = '0;
      clr     = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        ACCUM: begin
          if (in_valid) begin
            acc_en = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = FINAL;
          end
        end
        FINAL: begin
          fin_en  = 1'b1;
          state_d = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_acc or negedge rst_acc_n) begin
    if (!rst_acc_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q == ACCUM) || (state_q == FINAL);
  assign out_valid  = (state_q == DONE);
  assign sample_cnt = cnt_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    one_unit_acc_lane #(
      .DATA_W      (DATA_W),
      .LOG2_SAMPLES(LOG2_SAMPLES)
    ) u_lane (
      .clk_i   (clk_acc),
      .rst_n_i (rst_acc_n),
      .clr_i   (clr),
      .acc_en_i(acc_en),
      .fin_en_i(fin_en),
      .prod_i  (prod[k*DATA_W +: DATA_W]),
      .w_i     (w_cur[k*DATA_W +: DATA_W]),
      .w_new_o (w_new[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: doc/one_unit_acc.md
Name: one_unit_acc

Overview:
- Downstream stage of the 4x4 one-unit multiply stage.
- Consumes the 16 per-sample products z*(w^T z)^3, one sample per cycle, and accumulates them over 2^LOG2_SAMPLES samples.
- Then forms the FastICA fixed-point update w_new = E{z*g(w^T z)} - 3*w for all 16 lanes (4 vectors x 4 elements).
- Returns the updated weights to the controller/normaliser with a valid/ready handshake.

Parameters:
- DATA_W, 26, lane width; signed Q(DATA_W-FRAC_W).FRAC_W.
- FRAC_W, 13, fractional bits; carried through unchanged, no rescale needed.
- LANES, 16, number of parallel lanes (o11..o44 ordering; lane k = row*4+col).
- LOG2_SAMPLES, 10, log2 of samples per iteration; must be >= 1.
- ACC_W (localparam), DATA_W+LOG2_SAMPLES+2, accumulator width; the +2 guards the 3*w subtraction.

Ports:
- clk_acc  in  1  clock; all state updates on the rising edge.
- rst_acc_n  in  1  asynchronous reset, active-low.
- start  in  1  pulse: clear accumulators and begin a new iteration.
- in_valid  in  1  the current cycle carries one sample of products.
- prod  in  LANES*DATA_W  packed signed products; lane k at [k*DATA_W +: DATA_W].
- w_cur  in  LANES*DATA_W  packed current weights; must be stable from start until out_valid&&out_ready.
- busy  out  1  high in ACCUM or FINAL.
- sample_cnt  out  LOG2_SAMPLES  samples accepted so far in this iteration.
- out_valid  out  1  w_new valid; held until accepted.
- out_ready  in  1  consumer accepts w_new.
- w_new  out  LANES*DATA_W  packed updated weights.

Behaviour:
- Reset (async, rst_acc_n low):
  - state=IDLE; all accumulators, sample_cnt, w_new = 0.
  - busy=0, out_valid=0.
- States: IDLE, ACCUM, FINAL, DONE.
- IDLE:
  - start -> ACCUM: clear all accumulators and sample_cnt.
  - in_valid is ignored.
- ACCUM:
  - On in_valid: acc_k += sign-extended prod_k for every lane; sample_cnt += 1.
  - No in_valid: hold.
  - When in_valid and sample_cnt == 2^LOG2_SAMPLES-1: go to FINAL. sample_cnt wraps to 0.
- FINAL (exactly one cycle):
  - For every lane k: w_new_k = fit((acc_k >>> LOG2_SAMPLES) - ((w_k<<1)+w_k)).
  - All arithmetic is signed, at ACC_W width.
  - The shift is arithmetic (floor toward -inf), not round-to-nearest.
  - Register w_new; go to DONE.
- DONE:
  - out_valid=1 and w_new are held stable until out_ready.
  - out_valid && out_ready -> IDLE; out_valid drops the next cycle.
- Latency: out_valid rises 2 clock edges after the edge that accepts the last sample.
- start has priority in every state, including ACCUM, FINAL and DONE:
  - Abort the current work, drop out_valid, clear accumulators and sample_cnt, enter ACCUM.
  - If in_valid is high in the same cycle as start, that sample is NOT accumulated.
- in_valid is ignored in FINAL and DONE; the upstream stage must stall.
- out_ready is ignored unless out_valid=1.
- fit(): depends on ONE_UNIT_ACC_SAT_EN (see Optional Feature).
- The accumulator itself never overflows at ACC_W.

Optional Feature:
- Macro: ONE_UNIT_ACC_SAT_EN.
- Defined: fit() saturates the ACC_W result to [-2^(DATA_W-1), 2^(DATA_W-1)-1], i.e. [-33554432, 33554431] for 26 bits.
- Undefined: fit() takes the low DATA_W bits (two's-complement wrap). This matches the existing bit-slice truncation used elsewhere in the datapath.

Decomposition:
- Shared package fastica_pkg holds:
  - DATA_W=26, FRAC_W=13;
  - lane count 16;
  - state encoding typedef (IDLE/ACCUM/FINAL/DONE);
  - lane index helper constants.
- One natural sub-module, one_unit_acc_lane:
  - one lane's accumulator, 3*w subtraction and fit();
  - instantiated LANES times by a generate loop;
  - the FSM and counter stay in the top module.

Test Plan (LOG2_SAMPLES=2, i.e. 4 samples):
- Reset mid-ACCUM after 2 samples: assert rst_acc_n=0 -> immediately out_valid=0, busy=0, sample_cnt=0; the next start with all-zero products and w -> w_new=0.
- start; 4 samples, all lanes prod=8192 (1.0), w=0 -> out_valid 2 edges after the 4th sample; every lane w_new=8192.
- As above with w=8192 on all lanes -> w_new=8192-24576=-16384 on every lane; lane prod=0, w=-4096 on lane 5 -> lane 5 = 12288.
- Floor check: lane 0 samples 1,0,0,0 -> 0; lane 1 samples -1,0,0,0 -> -1; w=0.
- Overflow: prod=33554431 on all 4 samples, w=-33554432 -> SAT_EN: 33554431; without macro: the low 26 bits of 134217727 reinterpreted as signed = -1.
- Handshake and priority:
  - Hold out_ready=0 for 5 cycles -> out_valid and w_new stable; gaps in in_valid during ACCUM stretch the iteration without changing the result.
  - start during DONE -> out_valid drops, ACCUM resumes, and the concurrent in_valid sample is discarded.
